fetch_unit: RTL and testbench

Instruction-fetch stage placed directly downstream of the program counter register and upstream of decode. Reads the current PC, issues synchronous instruction-memory reads, buffers returned instructions in a 2-entry queue with a valid/ready handshake to decode, and drives the PC's `nextPC`/`change` pair. It handles sequential advance, branch/jump redirects from execute, and HALT detection, after which the PC is frozen.

---
 rtl/fetch_unit.sv | 75 +++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with 2-entry decode queue, redirect/HALT handling and PC nextPC/change drive; define FETCH_CNT_EN to enable the fetch_cnt pop counter
module fetch_unit #(
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_in,
  output logic [15:0] next_pc,
  output logic        change,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  input  logic        id_ready,
  output logic        halted,
  output logic [15:0] fetch_cnt
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state;
  logic [15:0] q_instr [2];
  logic [15:0] q_pc [2];
  logic [1:0] occ;
  logic inflight;
  logic [15:0] tag;
  logic pop, push, halt_push, issue, wr_idx;
  assign if_valid = occ != 2'd0;
  assign if_instr = q_instr[0];
  assign if_pc = q_pc[0];
  assign pop = if_valid && id_ready;
  assign push = inflight && !redirect_valid;
  assign halt_push = push && imem_rdata[15:12] == HALT_OPCODE;
  assign issue = state == RUN && !redirect_valid && !halt_push &&
                 ({1'b0, occ} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
  assign change = !reset && (redirect_valid || issue);
  assign next_pc = redirect_valid ? redirect_target : pc_in + 16'd1;
  assign imem_addr = pc_in;
  assign halted = state == HALTED;
  assign wr_idx = occ[0] ^ pop;
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      occ <= 2'd0;
      inflight <= 1'b0;
      tag <= 16'h0;
      q_instr[0] <= 16'h0;
      q_instr[1] <= 16'h0;
      q_pc[0] <= 16'h0;
      q_pc[1] <= 16'h0;
    end else begin
      inflight <= issue;
      if (issue) tag <= pc_in;
      state <= redirect_valid ? RUN : halt_push ? HALTED : state;
      occ <= redirect_valid ? 2'd0 : occ + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        q_instr[0] <= q_instr[1];
        q_pc[0] <= q_pc[1];
      end
      if (push) begin
        q_instr[wr_idx] <= imem_rdata;
        q_pc[wr_idx] <= tag;
      end
    end
`ifdef FETCH_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= 16'h0;
    else if (pop && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  assign fetch_cnt = cnt;
`else
  assign fetch_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with PC register, sync ROM and program-order reference stream
module tb_fetch_unit;
  logic clk, reset;
  logic [15:0] pc_in, next_pc, imem_addr, imem_rdata, redirect_target, if_instr, if_pc, fetch_cnt;
  logic change, redirect_valid, if_valid, id_ready, halted;
  logic [15:0] mem [256];
  logic [15:0] pc;
  logic [31:0] exp_q [$];
  int passed = 0, total = 0, n_pops = 0;
  logic [15:0] exp_cnt;
  logic hold_v;
  logic [31:0] hold_d;

  fetch_unit dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .next_pc(next_pc), .change(change),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom(logic [15:0] a);
    return mem[a[7:0]];
  endfunction

  assign pc_in = pc;
  always @(posedge clk) begin
    if (reset) pc <= 16'h0;
    else if (change) pc <= next_pc;
    imem_rdata <= rom(imem_addr);
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // Program order from a new start PC: sequential addresses up to and including the first HALT.
  task automatic refill(logic [15:0] t);
    logic [15:0] a = t;
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back({rom(a), a});
      if (rom(a) >= 16'hF000) break;
      a = a + 16'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (redirect_valid) refill(redirect_target);
    #1;
    redirect_valid = 0;
  endtask

  task automatic wait_halt(string n, int lim);
    int k = 0;
    while (!(halted && !if_valid) && k < lim) begin
      step();
      k++;
    end
    chk(n, {31'b0, halted && !if_valid}, 32'd1);
  endtask

  always @(negedge clk)
    if (reset) begin
      hold_v = 0;
      exp_cnt = 16'h0;
    end else begin
      if (redirect_valid) begin
        chk("redir_change", {31'b0, change}, 32'd1);
        chk("redir_npc", {16'b0, next_pc}, {16'b0, redirect_target});
      end else if (change) begin
        chk("seq_npc", {16'b0, next_pc}, {16'b0, pc_in + 16'd1});
        chk("issue_while_halted", {31'b0, halted}, 32'd0);
      end
      if (hold_v) begin
        chk("hold_valid", {31'b0, if_valid}, 32'd1);
        chk("hold_head", {if_instr, if_pc}, hold_d);
      end
      hold_v = if_valid && !id_ready && !redirect_valid;
      hold_d = {if_instr, if_pc};
`ifdef FETCH_CNT_EN
      chk("fetch_cnt", {16'b0, fetch_cnt}, {16'b0, exp_cnt});
`else
      chk("fetch_cnt", {16'b0, fetch_cnt}, 32'd0);
`endif
      if (if_valid && id_ready) begin
        n_pops++;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL pop_extra: got %h expected no delivery", {if_instr, if_pc});
        end else begin
          chk("deliver", {if_instr, if_pc}, exp_q.pop_front());
          if (if_instr[15:12] == 4'hF) chk("halt_flag", {31'b0, halted}, 32'd1);
        end
      end
    end

  initial begin
    int p0;
    reset = 1; id_ready = 1; redirect_valid = 0; redirect_target = 16'h0;
    for (int a = 0; a < 256; a++) mem[a] = {4'($urandom_range(0, 14)), 12'($urandom)};
    mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'h1004;
    mem[12] = 16'hF000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_change", {31'b0, change}, 32'd0);
    chk("rst_cnt", {16'b0, fetch_cnt}, 32'd0);
    chk("rst_instr", {16'b0, if_instr}, 32'd0);
    chk("rst_pc", {16'b0, if_pc}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    refill(16'h0);
    @(negedge clk);
    chk("lat_c0_valid", {31'b0, if_valid}, 32'd0);
    chk("issue_c0", {31'b0, change}, 32'd1);
    step();
    @(negedge clk);
    chk("lat_c1_valid", {31'b0, if_valid}, 32'd0);
    step();
    id_ready = 0;
    @(negedge clk);
    chk("lat_c2_valid", {31'b0, if_valid}, 32'd1);
    chk("lat_c2_pc", {16'b0, if_pc}, 32'd0);
    repeat (4) step();
    @(negedge clk);
    chk("stall_change", {31'b0, change}, 32'd0);
    chk("stall_pc", {16'b0, if_pc}, 32'd0);
    step();
    id_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("throughput", {31'b0, if_valid}, 32'd1);
      step();
    end
    wait_halt("halt_drain", 40);
    @(negedge clk);
    chk("halt_pc", {16'b0, pc}, 32'd13);
    chk("halt_change", {31'b0, change}, 32'd0);
    step();
    redirect_target = 16'h0010; redirect_valid = 1;
    step();
    @(negedge clk);
    chk("unhalt", {31'b0, halted}, 32'd0);
    chk("unhalt_pc", {16'b0, pc}, 32'h10);
    repeat (4) step();
    id_ready = 0;
    step(); step();
    redirect_target = 16'h0040; redirect_valid = 1; id_ready = 1;
    step();
    @(negedge clk);
    chk("rd_r1_valid", {31'b0, if_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("rd_r2_valid", {31'b0, if_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("rd_r3_valid", {31'b0, if_valid}, 32'd1);
    chk("rd_r3_pc", {16'b0, if_pc}, 32'h40);
    step();
    redirect_target = 16'hFFFF; redirect_valid = 1;
    step();
    @(negedge clk);
    chk("wrap_change", {31'b0, change}, 32'd1);
    chk("wrap_npc", {16'b0, next_pc}, 32'd0);
    wait_halt("wrap_halt", 60);
    @(negedge clk);
    chk("wrap_halt_pc", {16'b0, pc}, 32'd13);
    for (int a = 20; a < 256; a++) if ($urandom_range(0, 15) == 0) mem[a] = {4'hF, 12'($urandom)};
    p0 = n_pops;
    for (int i = 0; i < 1500; i++) begin
      step();
      id_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 19) == 0;
      redirect_target = $urandom_range(0, 7) == 0 ? 16'hFFF8 : 16'($urandom_range(0, 255));
    end
    step();
    chk("progress", {31'b0, n_pops - p0 >= 200}, 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
